// File: rtl/trigger_capture.sv
// Double-banked oscilloscope trace capture: rising-edge or timeout trigger fills the
// back bank, and the display swaps banks only on frame_start once a full trace is ready.
module trigger_capture #(
  parameter int DEPTH   = 64,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        adc_data,
  input  logic                     adc_valid,
  input  logic [DATA_W-1:0]        trig_level,
  input  logic                     trig_auto,
  input  logic                     frame_start,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     frame_valid,
  output logic [1:0]               state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t              cur_state, nxt_state;
  logic                front_bank;
  logic [AW-1:0]       wr_ptr;
  logic [CW-1:0]       to_cnt;
  logic [DATA_W-1:0]   prev;
  logic                prev_valid;

  logic                we;
  logic                swap;
  logic [AW-1:0]       wr_idx;
  logic                level_hit;
  logic                auto_hit;

  // Both banks live in one array; the bank select is the top address bit.
  logic [DATA_W-1:0]   mem [2*DEPTH];

  assign state     = cur_state;
  assign level_hit = prev_valid && (prev < trig_level) && (adc_data >= trig_level);
  assign auto_hit  = trig_auto && (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (reset) cur_state <= ARMED;
    else       cur_state <= nxt_state;
  end

  // NOTE: every output of this block is assigned a default first so no latch is inferred.
  always_comb begin
    nxt_state = cur_state;
    we        = 1'b0;
    swap      = 1'b0;
    wr_idx    = wr_ptr;
    unique case (cur_state)
      ARMED: begin
        if (adc_valid && (level_hit || auto_hit)) begin
          nxt_state = CAPTURE;
          we        = 1'b1;
          wr_idx    = '0;
        end
      end
      CAPTURE: begin
        if (adc_valid) begin
          we = 1'b1;
          if (wr_ptr == PTR_LAST) nxt_state = DONE;
        end
      end
      DONE: begin
        if (frame_start) begin
          nxt_state = ARMED;
          swap      = 1'b1;
        end
      end
      default: nxt_state = ARMED;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      front_bank  <= 1'b0;
      frame_valid <= 1'b0;
      wr_ptr      <= '0;
      to_cnt      <= '0;
      prev        <= '0;
      prev_valid  <= 1'b0;
    end else begin
      if (swap) begin
        front_bank  <= ~front_bank;
        frame_valid <= 1'b1;
        wr_ptr      <= '0;
        to_cnt      <= '0;
      end
      if (we) wr_ptr <= wr_idx + AW'(1);
      // Edge history only counts while armed, so the first sample after arming never triggers.
      if (cur_state == ARMED) begin
        if (adc_valid) begin
          prev       <= adc_data;
          prev_valid <= 1'b1;
          if (to_cnt != TO_LAST) to_cnt <= to_cnt + CW'(1);
        end
      end else begin
        prev_valid <= 1'b0;
      end
    end
  end

  // NOTE: the trace RAM is deliberately not reset; only control state is.
  always_ff @(posedge clk) begin
    if (we) mem[{~front_bank, wr_idx}] <= adc_data;
  end

  always_ff @(posedge clk) begin
    if (reset) rd_data <= '0;
    else       rd_data <= mem[{front_bank, rd_addr}];
  end

endmodule

// File: tb/tb_trigger_capture.sv
// Directed bench for trigger_capture (DEPTH=8, TIMEOUT=16): vector table for the level
// trigger and swap, then hand sequences for auto-trigger, late frame_start and reset abort.
module tb_trigger_capture;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] adc_data;
  logic       adc_valid;
  logic [7:0] trig_level;
  logic       trig_auto;
  logic       frame_start;
  logic [2:0] rd_addr;
  logic [7:0] rd_data;
  logic       frame_valid;
  logic [1:0] state;

  int n_cmp  = 0;
  int n_fail = 0;

  trigger_capture #(.DEPTH(8), .DATA_W(8), .TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .adc_data    (adc_data),
    .adc_valid   (adc_valid),
    .trig_level  (trig_level),
    .trig_auto   (trig_auto),
    .frame_start (frame_start),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_valid (frame_valid),
    .state       (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       fs;
    logic [1:0] exp_state;
    logic       exp_fv;
  } vec_t;

  vec_t tab[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] d, input logic fs);
    adc_valid   = v;
    adc_data    = d;
    frame_start = fs;
    @(posedge clk);
    #1;
    adc_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic rd_chk(input int addr, input logic [7:0] exp, input string name);
    rd_addr = 3'(addr);
    @(posedge clk);
    #1;
    check($sformatf("%s[%0d]", name, addr), 32'(rd_data), 32'(exp));
  endtask

  initial begin
    logic [7:0] trace_a [8];
    trace_a = '{8'd160, 8'd200, 8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd66};

    // Level trigger on the 120 -> 160 crossing, with gaps and an ignored frame_start in CAPTURE.
    tab.push_back('{1'b1, 8'd200, 1'b0, 2'd0, 1'b0}); // first sample after arming: no trigger
    tab.push_back('{1'b1, 8'd0,   1'b0, 2'd0, 1'b0});
    tab.push_back('{1'b1, 8'd40,  1'b0, 2'd0, 1'b0});
    tab.push_back('{1'b1, 8'd80,  1'b0, 2'd0, 1'b0});
    tab.push_back('{1'b1, 8'd120, 1'b0, 2'd0, 1'b0});
    tab.push_back('{1'b1, 8'd160, 1'b0, 2'd1, 1'b0}); // trigger, index 0
    tab.push_back('{1'b1, 8'd200, 1'b0, 2'd1, 1'b0});
    tab.push_back('{1'b0, 8'd77,  1'b0, 2'd1, 1'b0});
    tab.push_back('{1'b0, 8'd77,  1'b1, 2'd1, 1'b0}); // frame_start in CAPTURE ignored
    tab.push_back('{1'b0, 8'd77,  1'b0, 2'd1, 1'b0});
    tab.push_back('{1'b1, 8'd11,  1'b0, 2'd1, 1'b0});
    tab.push_back('{1'b0, 8'd88,  1'b0, 2'd1, 1'b0});
    tab.push_back('{1'b0, 8'd88,  1'b0, 2'd1, 1'b0});
    tab.push_back('{1'b0, 8'd88,  1'b0, 2'd1, 1'b0});
    tab.push_back('{1'b1, 8'd22,  1'b0, 2'd1, 1'b0});
    tab.push_back('{1'b1, 8'd33,  1'b0, 2'd1, 1'b0});
    tab.push_back('{1'b1, 8'd44,  1'b0, 2'd1, 1'b0});
    tab.push_back('{1'b1, 8'd55,  1'b0, 2'd1, 1'b0});
    tab.push_back('{1'b1, 8'd66,  1'b0, 2'd2, 1'b0}); // index 7 -> DONE
    tab.push_back('{1'b1, 8'd99,  1'b0, 2'd2, 1'b0}); // ignored in DONE
    tab.push_back('{1'b0, 8'd0,   1'b0, 2'd2, 1'b0});
    tab.push_back('{1'b0, 8'd0,   1'b1, 2'd0, 1'b1}); // swap

    reset       = 1'b1;
    adc_data    = '0;
    adc_valid   = 1'b0;
    trig_level  = 8'd128;
    trig_auto   = 1'b0;
    frame_start = 1'b0;
    rd_addr     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'(state), 32'd0);
    check("reset_fv", 32'(frame_valid), 32'd0);
    check("reset_rd_data", 32'(rd_data), 32'd0);
    reset = 1'b0;

    foreach (tab[i]) begin
      cyc(tab[i].valid, tab[i].data, tab[i].fs);
      check($sformatf("vec%0d_state", i), 32'(state), 32'(tab[i].exp_state));
      check($sformatf("vec%0d_fv", i), 32'(frame_valid), 32'(tab[i].exp_fv));
    end
    for (int i = 0; i < 8; i++) rd_chk(i, trace_a[i], "trace_a");

    // Auto-trigger on the 16th valid sample; frame_start on the last write is ignored.
    trig_auto = 1'b1;
    for (int i = 0; i < 15; i++) cyc(1'b1, 8'd50, 1'b0);
    check("auto_pre_state", 32'(state), 32'd0);
    cyc(1'b1, 8'd50, 1'b0);
    check("auto_trig_state", 32'(state), 32'd1);
    for (int i = 0; i < 6; i++) cyc(1'b1, 8'd50, 1'b0);
    check("auto_cap_state", 32'(state), 32'd1);
    cyc(1'b1, 8'd50, 1'b1);
    check("fs_on_last_state", 32'(state), 32'd2);
    rd_chk(0, 8'd160, "front_kept");
    cyc(1'b0, 8'd0, 1'b1);
    check("late_swap_state", 32'(state), 32'd0);
    check("late_swap_fv", 32'(frame_valid), 32'd1);
    for (int i = 0; i < 8; i++) rd_chk(i, 8'd50, "trace_auto");

    // With auto-trigger off, a flat input never triggers.
    trig_auto = 1'b0;
    for (int i = 0; i < 40; i++) cyc(1'b1, 8'd50, 1'b0);
    check("no_auto_state", 32'(state), 32'd0);

    // Reset in the middle of a capture, then a clean capture from index 0.
    cyc(1'b1, 8'd10, 1'b0);
    cyc(1'b1, 8'd200, 1'b0);
    check("abort_trig_state", 32'(state), 32'd1);
    for (int i = 1; i <= 3; i++) cyc(1'b1, 8'(200 + i), 1'b0);
    check("abort_cap_state", 32'(state), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_state", 32'(state), 32'd0);
    check("abort_fv", 32'(frame_valid), 32'd0);
    rd_chk(0, 8'd50, "abort_front");
    cyc(1'b1, 8'd130, 1'b0);
    check("rearm_first_state", 32'(state), 32'd0);
    cyc(1'b1, 8'd5, 1'b0);
    cyc(1'b1, 8'd140, 1'b0);
    check("rearm_trig_state", 32'(state), 32'd1);
    for (int i = 1; i < 8; i++) cyc(1'b1, 8'(140 + i), 1'b0);
    check("rearm_done_state", 32'(state), 32'd2);
    cyc(1'b0, 8'd0, 1'b1);
    check("rearm_swap_state", 32'(state), 32'd0);
    check("rearm_swap_fv", 32'(frame_valid), 32'd1);
    for (int i = 0; i < 8; i++) rd_chk(i, 8'(140 + i), "trace_rearm");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
